gate_sweep_checker: RTL and testbench

//  Self-running stimulus sweeper and result checker for the two-input gate labs.
//  - Upstream: drives every input vector into N_IMPL parallel gate implementations.
//  - Downstream: samples their outputs, compares each against a golden function,
//    and records mismatch counts and the first failure.
//  - Replaces hand-written #delay stimulus; synthesisable, so it also runs on the board.

---
 rtl/gate_lab_pkg.sv | 42 ++++
 rtl/gate_sweep_checker_hold_timer.sv | 30 +++
 rtl/gate_sweep_checker.sv | 144 ++++++++++++++
 tb/tb_gate_sweep_checker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_lab_pkg.sv
// Shared definitions for the two-input gate labs:
// golden-function selectors, sweeper state encoding, reference function.
package gate_lab_pkg;

  localparam int OP_OR  = 0;
  localparam int OP_AND = 1;
  localparam int OP_XOR = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // Reduces the low w bits of vec with the selected operator.
  function automatic logic golden_fn(
    input logic [31:0] vec,
    input int          w,
    input int          op
  );
    logic r_or;
    logic r_and;
    logic r_xor;
    r_or  = 1'b0;
    r_and = 1'b1;
    r_xor = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        r_or  = r_or | vec[i];
        r_and = r_and & vec[i];
        r_xor = r_xor ^ vec[i];
      end
    end
    case (op)
      OP_AND:  return r_and;
      OP_XOR:  return r_xor;
      default: return r_or;
    endcase
  endfunction

endpackage

// File: rtl/gate_sweep_checker_hold_timer.sv
// Load/expire down-counter: after load, expire pulses on the
// HOLD_CYCLES-th enabled cycle.
module hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(HOLD_CYCLES + 1);
  localparam logic [W-1:0] INIT = W'(HOLD_CYCLES);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= INIT;
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = en && (count == W'(1));

endmodule

// File: rtl/gate_sweep_checker.sv
// Self-running sweeper: drives every input vector to N_IMPL gate
// implementations, checks them against a golden reduce, logs errors.
module gate_sweep_checker
  import gate_lab_pkg::*;
#(
  parameter int IN_W        = 2,
  parameter int N_IMPL      = 3,
  parameter int HOLD_CYCLES = 10,
  parameter int OP          = 0,
  parameter int ERR_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [IN_W-1:0]   stim,
  input  logic [N_IMPL-1:0] dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [IN_W-1:0]   first_err_vec,
  output logic [N_IMPL-1:0] first_err_mask
);

  localparam int PW = $clog2(N_IMPL + 1);
  localparam int SW = ERR_W + PW;
  localparam logic [IN_W-1:0]  LAST    = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t state;
  state_t state_n;

  logic accept;
  logic step;
  logic t_load;
  logic t_en;
  logic expire;

  logic              golden;
  logic [N_IMPL-1:0] mism;
  logic [PW-1:0]     pop;
  logic [SW-1:0]     sum;
  logic [ERR_W-1:0]  err_sat;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (t_load),
    .en     (t_en),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    t_load  = 1'b0;
    t_en    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = SETTLE;
          accept  = 1'b1;
          t_load  = 1'b1;
        end
      end
      SETTLE: begin
        t_en = 1'b1;
        if (expire) state_n = CHECK;
      end
      CHECK: begin
        step = 1'b1;
        if (stim == LAST) begin
          state_n = DONE;
        end else begin
          state_n = SETTLE;
          t_load  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign golden = golden_fn(32'(stim), IN_W, OP);

  // Case-inequality in simulation so X/Z outputs count as failures.
  always_comb begin
    mism = '0;
`ifndef SYNTHESIS
    for (int i = 0; i < N_IMPL; i++) begin
      mism[i] = (dut_out[i] !== golden);
    end
`else
    mism = dut_out ^ {N_IMPL{golden}};
`endif
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_IMPL; i++) begin
      pop = pop + PW'(mism[i]);
    end
  end

  assign sum     = SW'(err_count) + SW'(pop);
  assign err_sat = (sum > SW'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];

  // err_count is zero until the first mismatch, so it marks "first".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim           <= '0;
      err_count      <= '0;
      first_err_vec  <= '0;
      first_err_mask <= '0;
    end else if (accept) begin
      stim           <= '0;
      err_count      <= '0;
      first_err_vec  <= '0;
      first_err_mask <= '0;
    end else if (step) begin
      if (stim != LAST) stim <= stim + IN_W'(1);
      err_count <= err_sat;
      if (err_count == '0 && mism != '0) begin
        first_err_vec  <= stim;
        first_err_mask <= mism;
      end
    end
  end

  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: table of impl fault modes
// plus hand sequences for busy-start, restart and mid-sweep reset.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] stim;
  logic [2:0] dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [1:0] first_err_vec;
  logic [2:0] first_err_mask;

  logic [1:0] stim1;
  logic [2:0] dut_out1;
  logic       busy1;
  logic       done1;
  logic       pass1;
  logic [0:0] err_count1;
  logic [1:0] first_err_vec1;
  logic [2:0] first_err_mask1;

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  gate_sweep_checker u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stim           (stim),
    .dut_out        (dut_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_vec  (first_err_vec),
    .first_err_mask (first_err_mask)
  );

  gate_sweep_checker #(
    .ERR_W(1)
  ) u_dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stim           (stim1),
    .dut_out        (dut_out1),
    .busy           (busy1),
    .done           (done1),
    .pass           (pass1),
    .err_count      (err_count1),
    .first_err_vec  (first_err_vec1),
    .first_err_mask (first_err_mask1)
  );

  // Modes: 0 ok, 1 impl1=AND, 2 impl2 stuck-1, 3 impl0=XOR,
  // 4 all inverted, 5 wrong everywhere except the CHECK cycle.
  function automatic logic [2:0] model(int m, logic [1:0] s, int c);
    logic [2:0] r;
    r = {3{s[0] | s[1]}};
    case (m)
      1: r[1] = s[0] & s[1];
      2: r[2] = 1'b1;
      3: r[0] = s[0] ^ s[1];
      4: r = ~r;
      5: if (c % 11 != 10) r = ~r;
      default: ;
    endcase
    return r;
  endfunction

  always_comb dut_out  = model(mode, stim, cyc);
  always_comb dut_out1 = ~{3{stim1[0] | stim1[1]}};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
  endtask

  task automatic sweep(input int pulse_at, input bit chk_stim,
                       output int n);
    pulse_start();
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1 cyc = k;
      start = 1'b0;
      if (k == pulse_at) start = 1'b1;
      if (chk_stim && k < 44) begin
        chk("stim_step", int'(stim), k / 11);
        chk("busy_mid", int'(busy), 1);
      end
      if (done) begin
        n = k;
        break;
      end
    end
    if (n < 0) chk("done_timeout", int'(done), 1);
  endtask

  typedef struct {
    int m;
    int err;
    int vec;
    int mask;
    int ps;
  } vec_t;

  vec_t tbl[6];
  int   n;

  initial begin
    tbl[0] = '{0, 0,  0, 0, 1};
    tbl[1] = '{1, 2,  1, 2, 0};
    tbl[2] = '{2, 1,  0, 4, 0};
    tbl[3] = '{3, 1,  3, 1, 0};
    tbl[4] = '{4, 12, 0, 7, 0};
    tbl[5] = '{5, 0,  0, 0, 1};

    rst_n = 1'b0;
    start = 1'b0;
    #12;
    chk("rst_stim", int'(stim), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_fvec", int'(first_err_vec), 0);
    chk("rst_fmask", int'(first_err_mask), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].m;
      sweep(-1, i == 0, n);
      chk("latency", n, 44);
      chk("busy_end", int'(busy), 0);
      chk("err_count", int'(err_count), tbl[i].err);
      chk("first_vec", int'(first_err_vec), tbl[i].vec);
      chk("first_mask", int'(first_err_mask), tbl[i].mask);
      chk("pass", int'(pass), tbl[i].ps);
      if (i == 0) begin
        chk("sat_err", int'(err_count1), 1);
        chk("sat_pass", int'(pass1), 0);
        chk("sat_done", int'(done1), 1);
        chk("sat_mask", int'(first_err_mask1), 7);
        chk("sat_vec", int'(first_err_vec1), 0);
      end
    end

    // start while busy is ignored
    mode = 1;
    sweep(20, 1'b0, n);
    chk("busy_start_lat", n, 44);
    chk("busy_start_err", int'(err_count), 2);

    // done holds, then a start in DONE restarts and clears
    mode = 4;
    sweep(-1, 1'b0, n);
    repeat (5) @(posedge clk);
    #1 chk("done_hold", int'(done), 1);
    chk("err_hold", int'(err_count), 12);
    pulse_start();
    chk("rs_done", int'(done), 0);
    chk("rs_pass", int'(pass), 0);
    chk("rs_err", int'(err_count), 0);
    chk("rs_busy", int'(busy), 1);
    chk("rs_stim", int'(stim), 0);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1 cyc = k;
      if (done) begin
        n = k;
        break;
      end
    end
    chk("rs_lat", n, 44);
    chk("rs_err_end", int'(err_count), 12);

    // reset mid-sweep with a recorded error
    mode = 1;
    pulse_start();
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1 cyc = k;
      if (stim == 2'd2) break;
    end
    chk("mid_stim_reached", int'(stim), 2);
    chk("mid_err_before", int'(err_count), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_stim", int'(stim), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_done", int'(done), 0);
    chk("mr_pass", int'(pass), 0);
    chk("mr_err", int'(err_count), 0);
    chk("mr_fvec", int'(first_err_vec), 0);
    chk("mr_fmask", int'(first_err_mask), 0);
    @(negedge clk) rst_n = 1'b1;
    mode = 0;
    sweep(-1, 1'b1, n);
    chk("post_rst_lat", n, 44);
    chk("post_rst_pass", int'(pass), 1);
    chk("post_rst_err", int'(err_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
